aha_axi_to_axilite_burst: RTL

//   AXI4 slave to AXI-Lite master bridge with full burst support (FIXED/INCR/WRAP, AxLEN 0..255).

---
 rtl/aha_axi_to_axilite_burst.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/aha_axi_to_axilite_burst.sv
// AXI4 slave to AXI-Lite master bridge: each AXI4 burst (FIXED/INCR/WRAP) is replayed as a
// sequence of single-beat AXI-Lite accesses; read and write paths run independently.
module aha_axi_to_axilite_burst #(
    parameter  int ID_WIDTH   = 4,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ID_WIDTH-1:0]   AXI_AWID,
    input  logic [ADDR_WIDTH-1:0] AXI_AWADDR,
    input  logic [7:0]            AXI_AWLEN,
    input  logic [2:0]            AXI_AWSIZE,
    input  logic [1:0]            AXI_AWBURST,
    input  logic                  AXI_AWVALID,
    output logic                  AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0] AXI_WDATA,
    input  logic [STRB_W-1:0]     AXI_WSTRB,
    input  logic                  AXI_WLAST,
    input  logic                  AXI_WVALID,
    output logic                  AXI_WREADY,
    output logic [ID_WIDTH-1:0]   AXI_BID,
    output logic [1:0]            AXI_BRESP,
    output logic                  AXI_BVALID,
    input  logic                  AXI_BREADY,
    input  logic [ID_WIDTH-1:0]   AXI_ARID,
    input  logic [ADDR_WIDTH-1:0] AXI_ARADDR,
    input  logic [7:0]            AXI_ARLEN,
    input  logic [2:0]            AXI_ARSIZE,
    input  logic [1:0]            AXI_ARBURST,
    input  logic                  AXI_ARVALID,
    output logic                  AXI_ARREADY,
    output logic [ID_WIDTH-1:0]   AXI_RID,
    output logic [DATA_WIDTH-1:0] AXI_RDATA,
    output logic [1:0]            AXI_RRESP,
    output logic                  AXI_RLAST,
    output logic                  AXI_RVALID,
    input  logic                  AXI_RREADY,
    output logic [ADDR_WIDTH-1:0] LITE_AWADDR,
    output logic                  LITE_AWVALID,
    input  logic                  LITE_AWREADY,
    output logic [DATA_WIDTH-1:0] LITE_WDATA,
    output logic [STRB_W-1:0]     LITE_WSTRB,
    output logic                  LITE_WVALID,
    input  logic                  LITE_WREADY,
    input  logic [1:0]            LITE_BRESP,
    input  logic                  LITE_BVALID,
    output logic                  LITE_BREADY,
    output logic [ADDR_WIDTH-1:0] LITE_ARADDR,
    output logic                  LITE_ARVALID,
    input  logic                  LITE_ARREADY,
    input  logic [DATA_WIDTH-1:0] LITE_RDATA,
    input  logic [1:0]            LITE_RRESP,
    input  logic                  LITE_RVALID,
    output logic                  LITE_RREADY
);

    localparam logic [2:0] MAX_SZ = 3'($clog2(STRB_W));

    typedef enum logic [1:0] {W_IDLE, W_BEAT, W_RESP, W_BRESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    // Beat size is clamped to the bus width; WRAP keeps the address inside the aligned window.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [2:0] sz,
                                                        input logic [7:0] len,
                                                        input logic [1:0] bt);
        logic [2:0]            esz;
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] inc;
        esz  = (sz > MAX_SZ) ? MAX_SZ : sz;
        step = ADDR_WIDTH'(1) << esz;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << esz) - ADDR_WIDTH'(1);
        inc  = a + step;
        case (bt)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | (inc & mask);
            default: return inc;
        endcase
    endfunction

    function automatic logic [1:0] rsp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    wstate_t               wstate_q;
    logic [ID_WIDTH-1:0]   wid_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [ADDR_WIDTH-1:0] waddr_d;
    logic [7:0]            wlen_q;
    logic [7:0]            wcnt_q;
    logic [2:0]            wsize_q;
    logic [1:0]            wburst_q;
    logic                  awready_q;
    logic                  lawvalid_q;
    logic                  wbeat_q;
    logic                  wdone_q;
    logic                  werr_q;
    logic                  lbready_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  w_fire;

    assign waddr_d      = next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
    assign w_fire       = wbeat_q & ~wdone_q & AXI_WVALID & LITE_WREADY;

    assign AXI_AWREADY  = awready_q;
    assign AXI_WREADY   = wbeat_q & ~wdone_q & LITE_WREADY;
    assign AXI_BID      = wid_q;
    assign AXI_BRESP    = bresp_q;
    assign AXI_BVALID   = bvalid_q;
    assign LITE_AWADDR  = waddr_q;
    assign LITE_AWVALID = lawvalid_q;
    assign LITE_WDATA   = AXI_WDATA;
    assign LITE_WSTRB   = AXI_WSTRB;
    assign LITE_WVALID  = wbeat_q & ~wdone_q & AXI_WVALID;
    assign LITE_BREADY  = lbready_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wstate_q   <= W_IDLE;
            wid_q      <= '0;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wcnt_q     <= '0;
            wsize_q    <= '0;
            wburst_q   <= '0;
            awready_q  <= 1'b1;
            lawvalid_q <= 1'b0;
            wbeat_q    <= 1'b0;
            wdone_q    <= 1'b0;
            werr_q     <= 1'b0;
            lbready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
        end else begin
            case (wstate_q)
                W_IDLE: if (AXI_AWVALID) begin
                    wid_q      <= AXI_AWID;
                    waddr_q    <= AXI_AWADDR;
                    wlen_q     <= AXI_AWLEN;
                    wcnt_q     <= AXI_AWLEN;
                    wsize_q    <= AXI_AWSIZE;
                    wburst_q   <= AXI_AWBURST;
                    awready_q  <= 1'b0;
                    lawvalid_q <= 1'b1;
                    wbeat_q    <= 1'b1;
                    wdone_q    <= 1'b0;
                    werr_q     <= 1'b0;
                    bresp_q    <= '0;
                    wstate_q   <= W_BEAT;
                end
                W_BEAT: begin
                    // Lite AW and W may complete in either order or together.
                    if (LITE_AWREADY) lawvalid_q <= 1'b0;
                    if (w_fire) begin
                        wdone_q <= 1'b1;
                        if (AXI_WLAST != (wcnt_q == 8'd0)) werr_q <= 1'b1;
                    end
                    if ((!lawvalid_q || LITE_AWREADY) && (wdone_q || w_fire)) begin
                        wbeat_q   <= 1'b0;
                        lbready_q <= 1'b1;
                        wstate_q  <= W_RESP;
                    end
                end
                W_RESP: if (LITE_BVALID) begin
                    lbready_q <= 1'b0;
                    if (wcnt_q == 8'd0) begin
                        bresp_q  <= rsp_max(rsp_max(bresp_q, LITE_BRESP), werr_q ? 2'b10 : 2'b00);
                        bvalid_q <= 1'b1;
                        wstate_q <= W_BRESP;
                    end else begin
                        bresp_q    <= rsp_max(bresp_q, LITE_BRESP);
                        wcnt_q     <= wcnt_q - 8'd1;
                        waddr_q    <= waddr_d;
                        lawvalid_q <= 1'b1;
                        wbeat_q    <= 1'b1;
                        wdone_q    <= 1'b0;
                        wstate_q   <= W_BEAT;
                    end
                end
                W_BRESP: if (AXI_BREADY) begin
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    wstate_q  <= W_IDLE;
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    rstate_t               rstate_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [ADDR_WIDTH-1:0] raddr_d;
    logic [7:0]            rlen_q;
    logic [7:0]            rcnt_q;
    logic [2:0]            rsize_q;
    logic [1:0]            rburst_q;
    logic                  arready_q;
    logic                  larvalid_q;
    logic                  rphase_q;

    assign raddr_d      = next_addr(raddr_q, rsize_q, rlen_q, rburst_q);

    assign AXI_ARREADY  = arready_q;
    assign AXI_RID      = rid_q;
    assign AXI_RDATA    = LITE_RDATA;
    assign AXI_RRESP    = rphase_q ? LITE_RRESP : 2'b00;
    assign AXI_RLAST    = rphase_q & (rcnt_q == 8'd0);
    assign AXI_RVALID   = rphase_q & LITE_RVALID;
    assign LITE_ARADDR  = raddr_q;
    assign LITE_ARVALID = larvalid_q;
    assign LITE_RREADY  = rphase_q & AXI_RREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rstate_q   <= R_IDLE;
            rid_q      <= '0;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rcnt_q     <= '0;
            rsize_q    <= '0;
            rburst_q   <= '0;
            arready_q  <= 1'b1;
            larvalid_q <= 1'b0;
            rphase_q   <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: if (AXI_ARVALID) begin
                    rid_q      <= AXI_ARID;
                    raddr_q    <= AXI_ARADDR;
                    rlen_q     <= AXI_ARLEN;
                    rcnt_q     <= AXI_ARLEN;
                    rsize_q    <= AXI_ARSIZE;
                    rburst_q   <= AXI_ARBURST;
                    arready_q  <= 1'b0;
                    larvalid_q <= 1'b1;
                    rstate_q   <= R_ADDR;
                end
                R_ADDR: if (LITE_ARREADY) begin
                    larvalid_q <= 1'b0;
                    rphase_q   <= 1'b1;
                    rstate_q   <= R_DATA;
                end
                R_DATA: if (LITE_RVALID && AXI_RREADY) begin
                    rphase_q <= 1'b0;
                    if (rcnt_q == 8'd0) begin
                        arready_q <= 1'b1;
                        rstate_q  <= R_IDLE;
                    end else begin
                        rcnt_q     <= rcnt_q - 8'd1;
                        raddr_q    <= raddr_d;
                        larvalid_q <= 1'b1;
                        rstate_q   <= R_ADDR;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

endmodule
